fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: owns the PC, issues imem reads, buffers fetched

---
 rtl/fetch_prefetch_queue_if.sv | 34 +++
 rtl/fetch_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: imem request/response, redirect/halt controls and decode handshake.
// master = the fetch queue; slave = the imem/decode environment around it.
`timescale 1ns/1ps
interface fetch_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic          imemREN;
    logic [AW-1:0] imemaddr;
    logic [DW-1:0] imemload;
    logic          ihit;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_instr;
    logic [AW-1:0] deq_pc;
    logic [AW-1:0] deq_npc;
    logic [OW-1:0] occupancy;

    modport master (
        output imemREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_npc, occupancy,
        input  imemload, ihit, redirect, redirect_pc, halt, deq_ready
    );

    modport slave (
        input  imemREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_npc, occupancy,
        output imemload, ihit, redirect, redirect_pc, halt, deq_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, issues imem reads and queues {pc, instr} for decode.
// Optional FETCH_BYPASS_EN: present an ihit word on deq_* in the same cycle when the queue is empty.
`timescale 1ns/1ps
module fetch_prefetch_queue #(
    parameter int unsigned PC_INIT = 0,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input logic                      CLK,
    input logic                      RST,
    fetch_prefetch_queue_if.master   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PC_RST = AW'(PC_INIT);

    typedef enum logic {RUN, HALTED} state_e;

    state_e        state_q, state_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ent_pc_q    [DEPTH];
    logic [AW-1:0] ent_pc_d    [DEPTH];
    logic [DW-1:0] ent_instr_q [DEPTH];
    logic [DW-1:0] ent_instr_d [DEPTH];

    logic          halted;
    logic          empty, full, q_pop;
    logic          fetch_ok, accept, wr_en, rd_en;
    logic          bypass_show, bypass_take;
    logic [PW-1:0] wr_idx, rd_idx;
    logic [AW-1:0] head_pc;

    // ---------------- RUN/HALTED state machine ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        halted = (state_q == HALTED);
    end

    // ---------------- queue status and handshake ----------------
    always_comb begin
        wr_idx = wr_ptr_q[PW-1:0];
        rd_idx = rd_ptr_q[PW-1:0];
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
        // Queue-side pop only: the slot freed when full is always a queued entry,
        // which keeps imemREN independent of the bypass path.
        q_pop    = ~empty & bus.deq_ready;
        fetch_ok = ~RST & ~halted & ~bus.redirect & (~full | q_pop);
        accept   = bus.ihit & fetch_ok;
`ifdef FETCH_BYPASS_EN
        bypass_show = empty & accept;
        bypass_take = empty & accept & bus.deq_ready;
`else
        bypass_show = 1'b0;
        bypass_take = 1'b0;
`endif
        wr_en = accept & ~bypass_take;
        rd_en = q_pop & ~bus.redirect;
    end

    // ---------------- next-state datapath ----------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pc_d        = pc_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        if (bus.redirect) begin
            rd_ptr_d = wr_ptr_q;
            pc_d     = bus.redirect_pc & ~AW'(3);
        end else begin
            if (accept) pc_d = pc_q + AW'(4);
            if (wr_en) begin
                ent_pc_d[wr_idx]    = pc_q;
                ent_instr_d[wr_idx] = bus.imemload;
                wr_ptr_d            = wr_ptr_q + {{PW{1'b0}}, 1'b1};
            end
            if (rd_en) rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pc_q     <= PC_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pc_q     <= pc_d;
        end
    end

    // Entry storage carries no reset: contents are only observed behind deq_valid.
    always_ff @(posedge CLK) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

    // ---------------- outputs ----------------
    always_comb begin
        head_pc       = bypass_show ? pc_q : ent_pc_q[rd_idx];
        bus.imemREN   = fetch_ok;
        bus.imemaddr  = pc_q;
        bus.deq_valid = ~empty | bypass_show;
        bus.deq_pc    = head_pc;
        bus.deq_instr = bypass_show ? bus.imemload : ent_instr_q[rd_idx];
        bus.deq_npc   = head_pc + AW'(4);
        bus.occupancy = OW'(wr_ptr_q - rd_ptr_q);
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
    localparam int unsigned PC_INIT = 0;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    fetch_prefetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] m_pcs [$];
    logic [DW-1:0] m_ins [$];
    logic [AW-1:0] m_pc;
    bit            m_halt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pcs.delete();
        m_ins.delete();
        m_pc   = AW'(PC_INIT);
        m_halt = 1'b0;
    endtask

    task automatic drive_idle();
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.ihit        = 1'b0;
        bus.deq_ready   = 1'b0;
        bus.imemload    = '0;
    endtask

    // Called a little after a rising edge; asserts RST away from the edge.
    task automatic do_reset();
        drive_idle();
        RST = 1'b1;
        #1;
        chk("rst_imemREN",   bus.imemREN,   0);
        chk("rst_deq_valid", bus.deq_valid, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_imemaddr",  bus.imemaddr,  PC_INIT);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare against the model mid-cycle, advance the model.
    task automatic step(input bit rd, input logic [AW-1:0] rpc, input bit h,
                        input bit ih, input bit rdy, input logic [DW-1:0] ins);
        int            n;
        bit            ren, byp, valid;
        logic [AW-1:0] hp;
        logic [DW-1:0] hi;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = h;
        bus.ihit        = ih;
        bus.deq_ready   = rdy;
        bus.imemload    = ins;
        @(negedge CLK);
        n   = m_pcs.size();
        ren = !m_halt && !rd && (n < int'(DEPTH) || (n > 0 && rdy));
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (n == 0) && ih && ren;
`endif
        valid = (n > 0) || byp;
        chk("imemREN",   bus.imemREN,   ren);
        chk("imemaddr",  bus.imemaddr,  m_pc);
        chk("occupancy", bus.occupancy, n);
        chk("deq_valid", bus.deq_valid, valid);
        if (valid) begin
            hp = byp ? m_pc : m_pcs[0];
            hi = byp ? ins  : m_ins[0];
            chk("deq_pc",    bus.deq_pc,    hp);
            chk("deq_instr", bus.deq_instr, hi);
            chk("deq_npc",   bus.deq_npc,   hp + AW'(4));
        end
        if (rd) begin
            m_pcs.delete();
            m_ins.delete();
            m_pc = rpc & ~AW'(3);
        end else if (byp && rdy) begin
            m_pc = m_pc + AW'(4);
        end else begin
            if (n > 0 && rdy) begin
                void'(m_pcs.pop_front());
                void'(m_ins.pop_front());
            end
            if (ih && ren) begin
                m_pcs.push_back(m_pc);
                m_ins.push_back(ins);
                m_pc = m_pc + AW'(4);
            end
        end
        if (h) m_halt = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive_idle();
        model_reset();
        #2;
        do_reset();

        // Streaming: ihit every cycle, decode always ready.
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 0, 1, 1, 32'h1000_0000 + i);
`ifndef FETCH_BYPASS_EN
            chk("s1_deq_pc",    bus.deq_pc,    4 * i);
            chk("s1_deq_valid", bus.deq_valid, 1);
`endif
            chk("s1_occ_le1", bus.occupancy <= 1, 1);
        end

        // Fill with decode stalled, then steady push+pop while full.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0, 32'h2000_0000 + i);
        chk("s2_occ_full",  bus.occupancy, 4);
        chk("s2_imemaddr",  bus.imemaddr,  32'h10);
        chk("s2_imemREN",   bus.imemREN,   0);
        step(0, '0, 0, 1, 0, 32'h2BAD_0000);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, 1, 1, 32'h2100_0000 + i);
            chk("s2_occ_steady", bus.occupancy, 4);
        end

        // Redirect with 3 queued and a same-cycle ihit.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, 32'h3000_0000 + i);
        chk("s3_occ_before", bus.occupancy, 3);
        step(1, 32'h103, 0, 1, 1, 32'hDEAD_BEEF);
        chk("s3_occ_after",  bus.occupancy, 0);
        chk("s3_imemaddr",   bus.imemaddr,  32'h100);
        chk("s3_deq_valid",  bus.deq_valid, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 1, 32'h3100_0000 + i);

        // Halt with 2 queued: drains in order, never fetches again.
        do_reset();
        for (int i = 0; i < 2; i++) step(0, '0, 0, 1, 0, 32'h4000_0000 + i);
        step(0, '0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 1, $urandom);
        chk("s4_deq_valid", bus.deq_valid, 0);
        chk("s4_imemREN",   bus.imemREN,   0);

        // Reset mid-stream with 3 queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, 32'h5000_0000 + i);
        chk("s5_occ_before", bus.occupancy, 3);
        do_reset();

`ifdef FETCH_BYPASS_EN
        // Empty queue: ihit word visible on deq_* in the same cycle.
        bus.ihit = 1'b1; bus.deq_ready = 1'b1; bus.imemload = 32'h2408_000A;
        #1;
        chk("s6_deq_valid", bus.deq_valid, 1);
        chk("s6_deq_instr", bus.deq_instr, 32'h2408_000A);
        step(0, '0, 0, 1, 1, 32'h2408_000A);
        chk("s6_occupancy", bus.occupancy, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 599) == 0,
                 $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 60, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
